// File: rtl/t05_htree_seq.sv
`default_nettype none
// ============================================================================
// Module      : t05_htree_seq
// Description : Huffman tree-build iteration sequencer. Asks FLV for a least
//               pair, runs the node builder, writes its nodes to SRAM.
// Revision    : 1.0 - initial release
// ============================================================================
module t05_htree_seq #(
    parameter int TIMEOUT_CYC = 1023,
    parameter int MAX_NODES   = 127
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        flv_req,
    input  logic        flv_done,
    output logic [3:0]  ht_en,
    input  logic [3:0]  ht_op_fin,
    input  logic [70:0] tree_node,
    input  logic [70:0] null1_node,
    input  logic [70:0] null2_node,
    output logic        sram_wr_req,
    output logic [6:0]  sram_wr_addr,
    output logic [70:0] sram_wr_data,
    input  logic        sram_wr_ack,
    output logic [6:0]  node_count,
    output logic [3:0]  op_fin
);

    localparam logic [3:0] c_st_idle   = 4'd0;
    localparam logic [3:0] c_st_flv    = 4'd1;
    localparam logic [3:0] c_st_run    = 4'd2;
    localparam logic [3:0] c_st_wtree  = 4'd3;
    localparam logic [3:0] c_st_wnull1 = 4'd4;
    localparam logic [3:0] c_st_wnull2 = 4'd5;
    localparam logic [3:0] c_st_gap    = 4'd6;
    localparam logic [3:0] c_st_done   = 4'd7;
    localparam logic [3:0] c_st_err    = 4'd8;

    localparam logic [9:0] c_wd_last   = 10'(TIMEOUT_CYC - 1);
    localparam logic [6:0] c_max_nodes = 7'(MAX_NODES);

    logic [3:0]  r_state;
    logic [3:0]  w_next;
    logic [9:0]  r_wd;
    logic [6:0]  r_count;
    logic [70:0] r_last_null1;
    logic [70:0] r_last_null2;

    logic        w_wr_st;
    logic        w_wait_st;
    logic        w_ack;
    logic        w_null1_new;
    logic        w_null2_new;
    logic        w_restart;
    logic [70:0] w_wr_word;

    assign w_wr_st     = (r_state == c_st_wtree) || (r_state == c_st_wnull1) ||
                         (r_state == c_st_wnull2);
    assign w_wait_st   = w_wr_st || (r_state == c_st_flv) || (r_state == c_st_run);
    assign w_ack       = w_wr_st && sram_wr_ack;
    assign w_null1_new = (null1_node != '0) && (null1_node != r_last_null1);
    assign w_null2_new = (null2_node != '0) && (null2_node != r_last_null2);
    assign w_restart   = start && ((r_state == c_st_idle) || (r_state == c_st_done));

    always_comb begin
        w_wr_word = '0;
        case (r_state)
            c_st_wtree:  w_wr_word = tree_node;
            c_st_wnull1: w_wr_word = null1_node;
            c_st_wnull2: w_wr_word = null2_node;
            default:     w_wr_word = '0;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_idle:  if (start)    w_next = c_st_flv;
            c_st_flv:   if (flv_done) w_next = c_st_run;
            c_st_run: begin
                // Error status wins over any other bit presented alongside it.
                if (ht_op_fin[3])              w_next = c_st_err;
                else if (ht_op_fin == 4'b0011) w_next = c_st_wtree;
                else if (ht_op_fin == 4'b0100) w_next = c_st_done;
            end
            c_st_wtree: begin
                if (w_ack) begin
                    if (r_count == c_max_nodes) w_next = c_st_err;
                    else if (w_null1_new)       w_next = c_st_wnull1;
                    else if (w_null2_new)       w_next = c_st_wnull2;
                    else                        w_next = c_st_gap;
                end
            end
            c_st_wnull1: if (w_ack) w_next = w_null2_new ? c_st_wnull2 : c_st_gap;
            c_st_wnull2: if (w_ack) w_next = c_st_gap;
            c_st_gap:    w_next = c_st_flv;
            c_st_done:   if (start) w_next = c_st_flv;
            c_st_err:    w_next = c_st_err;
            default:     w_next = c_st_idle;
        endcase
        if (w_wait_st && (w_next == r_state) && (r_wd == c_wd_last)) begin
            w_next = c_st_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_st_idle;
            r_wd         <= '0;
            r_count      <= '0;
            r_last_null1 <= '0;
            r_last_null2 <= '0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state) r_wd <= '0;
            else if (w_wait_st)    r_wd <= r_wd + 10'd1;

            if (w_restart) begin
                r_count      <= '0;
                r_last_null1 <= '0;
                r_last_null2 <= '0;
            end else begin
                if ((r_state == c_st_wtree) && w_ack && (r_count != c_max_nodes))
                    r_count <= r_count + 7'd1;
                if ((r_state == c_st_wnull1) && w_ack) r_last_null1 <= null1_node;
                if ((r_state == c_st_wnull2) && w_ack) r_last_null2 <= null2_node;
            end
        end
    end

    // Builder enable stays on through the writes so its node outputs hold.
    assign flv_req      = (r_state == c_st_flv);
    assign ht_en        = ((r_state == c_st_run) || w_wr_st) ? 4'b0011 : 4'b0000;
    assign sram_wr_req  = w_wr_st;
    assign sram_wr_addr = w_wr_word[70:64];
    assign sram_wr_data = w_wr_word;
    assign node_count   = r_count;
    assign op_fin       = (r_state == c_st_done) ? 4'b0100 :
                          (r_state == c_st_err)  ? 4'b1000 : 4'b0000;

endmodule
`default_nettype wire

// File: tb/tb_t05_htree_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_t05_htree_seq
// Description : Self-checking bench for t05_htree_seq with a node-write model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_t05_htree_seq;

    localparam int TIMEOUT = 1023;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        flv_req;
    logic        flv_done;
    logic [3:0]  ht_en;
    logic [3:0]  ht_op_fin;
    logic [70:0] tree_node;
    logic [70:0] null1_node;
    logic [70:0] null2_node;
    logic        sram_wr_req;
    logic [6:0]  sram_wr_addr;
    logic [70:0] sram_wr_data;
    logic        sram_wr_ack;
    logic [6:0]  node_count;
    logic [3:0]  op_fin;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          m_count;
    logic [70:0] m_last1;
    logic [70:0] m_last2;
    logic [70:0] v3;

    t05_htree_seq dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .flv_req      (flv_req),
        .flv_done     (flv_done),
        .ht_en        (ht_en),
        .ht_op_fin    (ht_op_fin),
        .tree_node    (tree_node),
        .null1_node   (null1_node),
        .null2_node   (null2_node),
        .sram_wr_req  (sram_wr_req),
        .sram_wr_addr (sram_wr_addr),
        .sram_wr_data (sram_wr_data),
        .sram_wr_ack  (sram_wr_ack),
        .node_count   (node_count),
        .op_fin       (op_fin)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [70:0] rnd71();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[70:0];
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; flv_done = 1'b0; ht_op_fin = 4'b0;
        tree_node = '0; null1_node = '0; null2_node = '0; sram_wr_ack = 1'b0;
        step(); step();
        rst_n = 1'b1;
        m_count = 0; m_last1 = '0; m_last2 = '0;
    endtask

    task automatic pulse_start();
        start = 1'b1; step(); start = 1'b0;
        m_count = 0; m_last1 = '0; m_last2 = '0;
    endtask

    // One builder iteration: expected writes derived from the dedup rules.
    task automatic iter(input logic [70:0] tr, input logic [70:0] n1, input logic [70:0] n2,
                        input int flv_dly, input int ack_dly, input bit poke);
        logic [70:0] q[$];
        int n;
        n = 0;
        while (!flv_req && n < 50) begin step(); n++; end
        chk("flv_req_wait", {127'd0, flv_req}, 128'd1);
        repeat (flv_dly) begin
            if (poke) start = 1'b1;
            step();
            start = 1'b0;
        end
        flv_done = 1'b1; step(); flv_done = 1'b0;
        chk("ht_run_en", {flv_req, ht_en}, {1'b0, 4'b0011});
        tree_node = tr; null1_node = n1; null2_node = n2; ht_op_fin = 4'b0011;
        q.push_back(tr);
        if (n1 != '0 && n1 != m_last1) begin q.push_back(n1); m_last1 = n1; end
        if (n2 != '0 && n2 != m_last2) begin q.push_back(n2); m_last2 = n2; end
        m_count++;
        step();
        foreach (q[i]) begin
            chk("wr_word", {sram_wr_req, ht_en, sram_wr_addr, sram_wr_data},
                {1'b1, 4'b0011, q[i][70:64], q[i]});
            repeat (ack_dly) begin
                step();
                chk("wr_hold", {sram_wr_req, sram_wr_addr, sram_wr_data},
                    {1'b1, q[i][70:64], q[i]});
            end
            sram_wr_ack = 1'b1; step(); sram_wr_ack = 1'b0;
        end
        chk("gap", {sram_wr_req, flv_req, ht_en, op_fin}, 128'd0);
        chk("gap_count", {121'd0, node_count}, 128'(m_count));
        ht_op_fin = 4'b0;
        step();
        chk("gap_to_flv", {flv_req, ht_en}, {1'b1, 4'b0000});
    endtask

    initial begin
        int n;
        logic [70:0] a, b, c;
        do_reset();
        rst_n = 1'b0;
        step();
        chk("reset_outs", {flv_req, ht_en, sram_wr_req, sram_wr_addr, sram_wr_data, node_count, op_fin},
            128'd0);
        rst_n = 1'b1;
        step();

        pulse_start();
        chk("start_flv", {121'd0, node_count, flv_req}, 128'd1);
        iter(71'd0, 71'd0, 71'd0, 5, 0, 0);
        v3 = {7'd3, 64'h0123_4567_89ab_cdef};
        iter({7'd1, 64'h11}, v3, 71'd0, 1, 1, 0);
        iter({7'd2, 64'h22}, v3, 71'd0, 0, 0, 0);
        iter({7'd4, 64'h44}, 71'd0, {7'd5, 64'h55}, 2, 20, 0);

        for (int k = 0; k < 24; k++) begin
            a = rnd71();
            case ($urandom_range(0, 2))
                0:       b = '0;
                1:       b = m_last1;
                default: b = rnd71() | 71'd1;
            endcase
            case ($urandom_range(0, 2))
                0:       c = '0;
                1:       c = m_last2;
                default: c = rnd71() | 71'd1;
            endcase
            iter(a, b, c, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        // Tree done: no write, held until a new start.
        flv_done = 1'b1; step(); flv_done = 1'b0;
        ht_op_fin = 4'b0100;
        step();
        chk("done_state", {op_fin, ht_en, sram_wr_req, flv_req}, {4'b0100, 4'b0, 2'b00});
        ht_op_fin = 4'b0;
        repeat (3) step();
        chk("done_held", {op_fin, ht_en, sram_wr_req}, {4'b0100, 4'b0, 1'b0});
        pulse_start();
        chk("restart", {flv_req, op_fin, node_count}, {1'b1, 4'b0, 7'd0});
        iter({7'd6, 64'h66}, v3, 71'd0, 0, 0, 0);

        while (m_count < 127) iter(rnd71(), 71'd0, 71'd0, 0, 0, 0);
        flv_done = 1'b1; step(); flv_done = 1'b0;
        tree_node = {7'd9, 64'h99}; ht_op_fin = 4'b0011;
        step();
        chk("ovf_req", {121'd0, sram_wr_req, sram_wr_addr}, {121'd0, 1'b1, 7'd9});
        sram_wr_ack = 1'b1; step(); sram_wr_ack = 1'b0;
        chk("ovf_err", {op_fin, node_count, sram_wr_req, ht_en}, {4'b1000, 7'd127, 1'b0, 4'b0});

        do_reset();
        pulse_start();
        flv_done = 1'b1; step(); flv_done = 1'b0;
        ht_op_fin = 4'b1011;
        step();
        chk("prio_err", {op_fin, sram_wr_req, node_count}, {4'b1000, 1'b0, 7'd0});

        do_reset();
        pulse_start();
        flv_done = 1'b1; step(); flv_done = 1'b0;
        tree_node = {7'd7, 64'h77}; ht_op_fin = 4'b0011;
        step();
        chk("pre_rst_req", {127'd0, sram_wr_req}, 128'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst", {sram_wr_req, ht_en, sram_wr_data, op_fin}, 128'd0);

        do_reset();
        pulse_start();
        n = 0;
        while (flv_req && n < 2000) begin n++; step(); end
        chk("wd_cycles", 128'(n), 128'(TIMEOUT));
        chk("wd_err", {124'd0, op_fin}, {124'd0, 4'b1000});
        start = 1'b1; repeat (4) step(); start = 1'b0;
        chk("err_held", {op_fin, flv_req}, {4'b1000, 1'b0});
        rst_n = 1'b0;
        #1;
        chk("err_cleared", {124'd0, op_fin}, 128'd0);
        step();
        rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
